// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//   Run controller for a 4-digit packed-BCD stopwatch datapath. It turns three
//   raw push buttons into Start/Stop, Lap and Clear actions. It issues the
//   count-enable tick from a prescaler and the synchronous clear. It also
//   freezes the displayed value for lap times and stops at full scale.
//
// Parameters
//   TICK_DIV   clock cycles per count increment (>= 1)
//   TICK_W     prescaler width, 2**TICK_W >= TICK_DIV
//   MAX_COUNT  full-scale datapath value; no enable is issued past it
//
// Ports
//   Clock      in   system clock, rising edge
//   Resetn     in   asynchronous active-low reset
//   StartStop  in   raw button, active high, asynchronous to Clock
//   Lap        in   raw button, active high, asynchronous to Clock
//   Clear      in   raw button, active high, asynchronous to Clock
//   Count      in   current datapath value (packed BCD, 16 bits)
//   CountEn    out  one-cycle increment strobe to the datapath
//   CountClr   out  one-cycle synchronous clear to the datapath
//   Display    out  value routed to the HEX decoders
//   Running    out  high while counting
//   LapHeld    out  high while the display is frozen
//   Overflow   out  sticky full-scale flag
//   state_dbg  out  current FSM state encoding (debug observation)
//
// Handshake: there is no valid/ready pair here. CountEn and CountClr are
// single-cycle strobes that the datapath samples on the next rising edge.
// The datapath has no back-pressure.
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int          TICK_DIV  = 500000,
  parameter int          TICK_W    = 19,
  parameter logic [15:0] MAX_COUNT = 16'h9999
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        StartStop,
  input  logic        Lap,
  input  logic        Clear,
  input  logic [15:0] Count,
  output logic        CountEn,
  output logic        CountClr,
  output logic [15:0] Display,
  output logic        Running,
  output logic        LapHeld,
  output logic        Overflow,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_FULL  = 3'd4
  } state_t;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

  state_t              state;
  logic [TICK_W-1:0]   prescaler;
  logic [15:0]         lap_q;

  // Button conditioning, bit order {Clear, Lap, StartStop}. Two flops
  // synchronise the raw input. The third flop holds the previous
  // synchronised value, so a held button yields a single edge.
  logic [2:0] btn_s1;
  logic [2:0] btn_s2;
  logic [2:0] btn_prev;
  logic [2:0] btn_edge;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      btn_s1   <= 3'b000;
      btn_s2   <= 3'b000;
      btn_prev <= 3'b000;
    end else begin
      btn_s1   <= {Clear, Lap, StartStop};
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
    end
  end

  assign btn_edge = btn_s2 & ~btn_prev;

  logic ss_e;
  logic lap_e;
  logic clr_e;
  assign ss_e  = btn_edge[0];
  assign lap_e = btn_edge[1];
  assign clr_e = btn_edge[2];

  // A tick is the last cycle of a prescaler period while running. The
  // enable is combinational so that the full-scale compare sees the value
  // that the datapath would actually increment.
  logic tick;
  logic at_max;
  assign tick    = (state == S_RUN) && (prescaler == TICK_LAST);
  assign at_max  = (Count == MAX_COUNT);
  assign CountEn = tick && !at_max;

  assign Running   = (state == S_RUN);
  assign Display   = LapHeld ? lap_q : Count;
  assign state_dbg = state;

  // Clear acts only when not counting. In those states it outranks
  // StartStop and Lap, so a simultaneous press drops the other edges.
  logic clr_act;
  assign clr_act = clr_e &&
                   ((state == S_IDLE) || (state == S_PAUSE) || (state == S_FULL));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= S_INIT;
      prescaler <= '0;
      lap_q     <= 16'h0000;
      CountClr  <= 1'b0;
      LapHeld   <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      CountClr <= 1'b0;
      if (clr_act) begin
        CountClr  <= 1'b1;
        prescaler <= '0;
        LapHeld   <= 1'b0;
        Overflow  <= 1'b0;
        state     <= S_IDLE;
      end else begin
        case (state)
          S_INIT: begin
            // First cycle after reset release: clear the datapath once.
            CountClr  <= 1'b1;
            prescaler <= '0;
            state     <= S_IDLE;
          end
          S_IDLE: begin
            if (ss_e) begin
              prescaler <= '0;
              state     <= S_RUN;
            end
          end
          S_RUN: begin
            prescaler <= tick ? '0 : prescaler + TICK_ONE;
            // Reaching full scale wins over a Stop press in the same cycle.
            if (tick && at_max) begin
              Overflow <= 1'b1;
              state    <= S_FULL;
            end else if (ss_e) begin
              state <= S_PAUSE;
            end
            if (lap_e && !ss_e) begin
              LapHeld <= !LapHeld;
              if (!LapHeld) lap_q <= Count;
            end
          end
          S_PAUSE: begin
            // The prescaler is held so that a resume finishes the
            // partial period.
            if (ss_e) begin
              state <= S_RUN;
            end else if (lap_e) begin
              LapHeld <= !LapHeld;
              if (!LapHeld) lap_q <= Count;
            end
          end
          S_FULL: begin
            state <= S_FULL;
          end
          default: begin
            state <= S_INIT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//   Drives stopwatch_ctrl with TICK_DIV=4 against a BCD counter datapath
//   model. DUT outputs are compared every cycle against a behavioural
//   reference of the stopwatch rules. Each scenario also checks the absolute
//   values that follow from those rules.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  localparam int          TICK_DIV  = 4;
  localparam int          TICK_W    = 3;
  localparam logic [15:0] MAX_COUNT = 16'h9999;

  localparam int M_INIT  = 0;
  localparam int M_IDLE  = 1;
  localparam int M_RUN   = 2;
  localparam int M_PAUSE = 3;
  localparam int M_FULL  = 4;

  // ---------------- clock / reset ----------------
  logic        Clock     = 1'b0;
  logic        Resetn    = 1'b0;
  logic        StartStop = 1'b0;
  logic        Lap       = 1'b0;
  logic        Clear     = 1'b0;
  logic [15:0] Count     = 16'h0042;
  logic        CountEn;
  logic        CountClr;
  logic [15:0] Display;
  logic        Running;
  logic        LapHeld;
  logic        Overflow;
  logic [2:0]  state_dbg;

  int checks = 0;
  int passes = 0;

  always #5 Clock = ~Clock;

  stopwatch_ctrl #(
    .TICK_DIV (TICK_DIV),
    .TICK_W   (TICK_W),
    .MAX_COUNT(MAX_COUNT)
  ) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .StartStop(StartStop),
    .Lap      (Lap),
    .Clear    (Clear),
    .Count    (Count),
    .CountEn  (CountEn),
    .CountClr (CountClr),
    .Display  (Display),
    .Running  (Running),
    .LapHeld  (LapHeld),
    .Overflow (Overflow),
    .state_dbg(state_dbg)
  );

  // ---------------- datapath model (BCD counter) ----------------
  logic        force_en  = 1'b0;
  logic [15:0] force_val = 16'h0000;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always @(posedge Clock) begin
    if (force_en)      Count <= force_val;
    else if (CountClr) Count <= 16'h0000;
    else if (CountEn)  Count <= bcd_inc(Count);
  end

  // ---------------- reference model ----------------
  // A raw press first sampled at edge n-2, and not at edge n-3, acts at
  // edge n. m_phase counts the run cycles already spent in the current
  // count period.
  int          m_mode  = M_INIT;
  int          m_phase = 0;
  logic        m_held  = 1'b0;
  logic [15:0] m_lap   = 16'h0000;
  logic        m_ovf   = 1'b0;
  logic        m_clr   = 1'b0;
  logic [2:0]  h_ss    = 3'b000;
  logic [2:0]  h_lap   = 3'b000;
  logic [2:0]  h_clr   = 3'b000;

  logic e_ss;
  logic e_lap;
  logic e_clr;
  assign e_ss  = h_ss[1]  & ~h_ss[2];
  assign e_lap = h_lap[1] & ~h_lap[2];
  assign e_clr = h_clr[1] & ~h_clr[2];

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      m_mode  <= M_INIT;
      m_phase <= 0;
      m_held  <= 1'b0;
      m_lap   <= 16'h0000;
      m_ovf   <= 1'b0;
      m_clr   <= 1'b0;
      h_ss    <= 3'b000;
      h_lap   <= 3'b000;
      h_clr   <= 3'b000;
    end else begin
      h_ss  <= {h_ss[1:0], StartStop};
      h_lap <= {h_lap[1:0], Lap};
      h_clr <= {h_clr[1:0], Clear};
      m_clr <= 1'b0;
      if (m_mode == M_INIT) begin
        m_clr  <= 1'b1;
        m_mode <= M_IDLE;
      end else if (e_clr && m_mode != M_RUN) begin
        m_clr   <= 1'b1;
        m_phase <= 0;
        m_held  <= 1'b0;
        m_ovf   <= 1'b0;
        m_mode  <= M_IDLE;
      end else if (m_mode == M_IDLE) begin
        if (e_ss) begin
          m_mode  <= M_RUN;
          m_phase <= 0;
        end
      end else if (m_mode == M_PAUSE) begin
        if (e_ss) m_mode <= M_RUN;
        else if (e_lap) begin
          m_held <= !m_held;
          if (!m_held) m_lap <= Count;
        end
      end else if (m_mode == M_RUN) begin
        m_phase <= (m_phase + 1) % TICK_DIV;
        if (m_phase == TICK_DIV - 1 && Count == MAX_COUNT) begin
          m_mode <= M_FULL;
          m_ovf  <= 1'b1;
        end else if (e_ss) begin
          m_mode <= M_PAUSE;
        end
        if (e_lap && !e_ss) begin
          m_held <= !m_held;
          if (!m_held) m_lap <= Count;
        end
      end
    end
  end

  function automatic logic exp_en();
    return (m_mode == M_RUN) && (m_phase == TICK_DIV - 1) && (Count != MAX_COUNT);
  endfunction

  function automatic logic [15:0] exp_disp();
    return m_held ? m_lap : Count;
  endfunction

  // ---------------- driver tasks ----------------
  // Raise a button now (at a falling edge) and drop it after 'hold' falling edges.
  task automatic press(input int which, input int hold);
    case (which)
      0:       StartStop = 1'b1;
      1:       Lap       = 1'b1;
      default: Clear     = 1'b1;
    endcase
    fork
      begin
        automatic int w = which;
        automatic int h = hold;
        repeat (h) @(negedge Clock);
        case (w)
          0:       StartStop = 1'b0;
          1:       Lap       = 1'b0;
          default: Clear     = 1'b0;
        endcase
      end
    join_none
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge Clock);
    checks++; if (CountEn  !== 1'b0) $display("FAIL reset_en: got %b expected 0", CountEn);  else passes++;
    checks++; if (CountClr !== 1'b0) $display("FAIL reset_clr: got %b expected 0", CountClr); else passes++;
    checks++; if (Running  !== 1'b0) $display("FAIL reset_run: got %b expected 0", Running);  else passes++;
    checks++; if (LapHeld  !== 1'b0) $display("FAIL reset_lap: got %b expected 0", LapHeld);  else passes++;
    checks++; if (Overflow !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", Overflow); else passes++;
    checks++; if (Display  !== 16'h0042) $display("FAIL reset_disp: got %h expected 0042", Display); else passes++;
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    checks++; if (CountClr !== 1'b1) $display("FAIL init_clr: got %b expected 1", CountClr); else passes++;
    checks++; if (Running  !== 1'b0) $display("FAIL init_run: got %b expected 0", Running);  else passes++;
    @(negedge Clock);
    checks++; if (CountClr !== 1'b0) $display("FAIL init_clr_once: got %b expected 0", CountClr); else passes++;
    checks++; if (Display  !== 16'h0000) $display("FAIL init_disp: got %h expected 0000", Display); else passes++;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clock);
      checks++; if (CountEn !== 1'b0) $display("FAIL idle_en: got %b expected 0", CountEn); else passes++;
      checks++; if (Running !== 1'b0) $display("FAIL idle_run: got %b expected 0", Running); else passes++;
    end
  endtask

  task automatic test_run();
    int en_cnt;
    press(0, 2);
    for (int c = 1; c <= 3; c++) begin
      @(negedge Clock);
      checks++; if (Running !== (c == 3)) $display("FAIL start_latency c%0d: got %b expected %b", c, Running, (c == 3)); else passes++;
    end
    en_cnt = (CountEn === 1'b1) ? 1 : 0;
    for (int c = 2; c <= 40; c++) begin
      @(negedge Clock);
      if (CountEn === 1'b1) en_cnt++;
      checks++; if (CountEn  !== exp_en())      $display("FAIL run_en: got %b expected %b", CountEn, exp_en()); else passes++;
      checks++; if (CountClr !== m_clr)         $display("FAIL run_clr: got %b expected %b", CountClr, m_clr); else passes++;
      checks++; if (Running  !== (m_mode == M_RUN)) $display("FAIL run_running: got %b expected %b", Running, (m_mode == M_RUN)); else passes++;
      checks++; if (Display  !== exp_disp())    $display("FAIL run_disp: got %h expected %h", Display, exp_disp()); else passes++;
    end
    checks++; if (en_cnt != 10) $display("FAIL run_en_count: got %0d expected 10", en_cnt); else passes++;
    @(negedge Clock);
    checks++; if (Count !== 16'h0010) $display("FAIL run_count40: got %h expected 0010", Count); else passes++;
  endtask

  task automatic test_pause();
    logic [15:0] snap;
    int          en_cnt;
    int          d;
    d = $urandom_range(0, 3);
    repeat (d) @(negedge Clock);
    press(0, 2);
    for (int c = 1; c <= 3; c++) begin
      @(negedge Clock);
      checks++; if (CountEn !== exp_en()) $display("FAIL pause_en_pre: got %b expected %b", CountEn, exp_en()); else passes++;
    end
    checks++; if (Running !== 1'b0) $display("FAIL pause_running: got %b expected 0", Running); else passes++;
    snap = Count;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clock);
      checks++; if (CountEn  !== 1'b0)               $display("FAIL pause_en: got %b expected 0", CountEn); else passes++;
      checks++; if (Running  !== (m_mode == M_RUN))  $display("FAIL pause_mode: got %b expected %b", Running, (m_mode == M_RUN)); else passes++;
      checks++; if (Display  !== exp_disp())         $display("FAIL pause_disp: got %h expected %h", Display, exp_disp()); else passes++;
    end
    checks++; if (Count !== snap) $display("FAIL pause_hold: got %h expected %h", Count, snap); else passes++;
    press(0, 2);
    for (int c = 1; c <= 3; c++) begin
      @(negedge Clock);
      checks++; if (Running !== (c == 3)) $display("FAIL resume_latency c%0d: got %b expected %b", c, Running, (c == 3)); else passes++;
    end
    en_cnt = 0;
    for (int c = 0; c < TICK_DIV; c++) begin
      if (c > 0) @(negedge Clock);
      if (CountEn === 1'b1) en_cnt++;
      checks++; if (CountEn !== exp_en()) $display("FAIL resume_en: got %b expected %b", CountEn, exp_en()); else passes++;
    end
    checks++; if (en_cnt != 1) $display("FAIL resume_en_count: got %0d expected 1", en_cnt); else passes++;
  endtask

  task automatic test_lap();
    press(1, 2);
    force_val = 16'h0123;
    force_en  = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge Clock);
      if (c == 2) force_en = 1'b0;
    end
    checks++; if (LapHeld !== 1'b1)     $display("FAIL lap_held: got %b expected 1", LapHeld); else passes++;
    checks++; if (Display !== 16'h0123) $display("FAIL lap_disp: got %h expected 0123", Display); else passes++;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clock);
      checks++; if (Display !== 16'h0123)  $display("FAIL lap_frozen: got %h expected 0123", Display); else passes++;
      checks++; if (CountEn !== exp_en())  $display("FAIL lap_en: got %b expected %b", CountEn, exp_en()); else passes++;
      checks++; if (LapHeld !== m_held)    $display("FAIL lap_model: got %b expected %b", LapHeld, m_held); else passes++;
    end
    checks++; if ((Count != 16'h0123) !== 1'b1) $display("FAIL lap_count_moves: got %h expected not 0123", Count); else passes++;
    press(1, 2);
    repeat (3) @(negedge Clock);
    checks++; if (LapHeld !== 1'b0)  $display("FAIL lap_release: got %b expected 0", LapHeld); else passes++;
    checks++; if (Display !== Count) $display("FAIL lap_release_disp: got %h expected %h", Display, Count); else passes++;
  endtask

  task automatic test_full();
    force_val = MAX_COUNT;
    force_en  = 1'b1;
    @(negedge Clock);
    force_en = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clock);
      checks++; if (CountEn  !== exp_en())          $display("FAIL full_en: got %b expected %b", CountEn, exp_en()); else passes++;
      checks++; if (Running  !== (m_mode == M_RUN)) $display("FAIL full_running: got %b expected %b", Running, (m_mode == M_RUN)); else passes++;
      checks++; if (Overflow !== m_ovf)             $display("FAIL full_ovf: got %b expected %b", Overflow, m_ovf); else passes++;
    end
    checks++; if (Running  !== 1'b0)      $display("FAIL full_stopped: got %b expected 0", Running); else passes++;
    checks++; if (Overflow !== 1'b1)      $display("FAIL full_flag: got %b expected 1", Overflow); else passes++;
    checks++; if (Count    !== MAX_COUNT) $display("FAIL full_count: got %h expected 9999", Count); else passes++;
    press(0, 2);
    repeat (6) @(negedge Clock);
    checks++; if (Running !== 1'b0) $display("FAIL full_ss_ignored: got %b expected 0", Running); else passes++;
    press(2, 2);
    repeat (3) @(negedge Clock);
    checks++; if (CountClr !== 1'b1) $display("FAIL full_clear_clr: got %b expected 1", CountClr); else passes++;
    checks++; if (Overflow !== 1'b0) $display("FAIL full_clear_ovf: got %b expected 0", Overflow); else passes++;
    @(negedge Clock);
    checks++; if (Count   !== 16'h0000) $display("FAIL full_clear_count: got %h expected 0000", Count); else passes++;
    checks++; if (Running !== 1'b0)     $display("FAIL full_clear_idle: got %b expected 0", Running); else passes++;
  endtask

  task automatic test_simultaneous();
    for (int c = 0; c <= 40; c++) begin
      @(negedge Clock);
      checks++; if (CountEn  !== exp_en())          $display("FAIL sim_en c%0d: got %b expected %b", c, CountEn, exp_en()); else passes++;
      checks++; if (CountClr !== m_clr)             $display("FAIL sim_clr c%0d: got %b expected %b", c, CountClr, m_clr); else passes++;
      checks++; if (Running  !== (m_mode == M_RUN)) $display("FAIL sim_running c%0d: got %b expected %b", c, Running, (m_mode == M_RUN)); else passes++;
      checks++; if (LapHeld  !== m_held)            $display("FAIL sim_lap c%0d: got %b expected %b", c, LapHeld, m_held); else passes++;
      checks++; if (Display  !== exp_disp())        $display("FAIL sim_disp c%0d: got %h expected %h", c, Display, exp_disp()); else passes++;
      if (c == 19) begin
        checks++; if (CountClr !== 1'b1) $display("FAIL sim_only_clear_clr: got %b expected 1", CountClr); else passes++;
        checks++; if (LapHeld  !== 1'b0) $display("FAIL sim_only_clear_lap: got %b expected 0", LapHeld); else passes++;
        checks++; if (Running  !== 1'b0) $display("FAIL sim_only_clear_run: got %b expected 0", Running); else passes++;
      end
      if (c == 20) begin
        checks++; if (Count !== 16'h0000) $display("FAIL sim_cleared: got %h expected 0000", Count); else passes++;
      end
      if (c == 0 || c == 10 || c == 22) press(0, 2);
      if (c == 5) press(1, 2);
      if (c == 16) begin
        press(0, 2);
        press(1, 2);
        press(2, 2);
      end
    end
  endtask

  task automatic test_reset_mid();
    press(1, 2);
    repeat ($urandom_range(5, 9)) @(negedge Clock);
    @(posedge Clock);
    #2;
    Resetn = 1'b0;
    #1;
    checks++; if (CountEn  !== 1'b0)  $display("FAIL rst_mid_en: got %b expected 0", CountEn);  else passes++;
    checks++; if (CountClr !== 1'b0)  $display("FAIL rst_mid_clr: got %b expected 0", CountClr); else passes++;
    checks++; if (Running  !== 1'b0)  $display("FAIL rst_mid_run: got %b expected 0", Running);  else passes++;
    checks++; if (LapHeld  !== 1'b0)  $display("FAIL rst_mid_lap: got %b expected 0", LapHeld);  else passes++;
    checks++; if (Overflow !== 1'b0)  $display("FAIL rst_mid_ovf: got %b expected 0", Overflow); else passes++;
    checks++; if (Display  !== Count) $display("FAIL rst_mid_disp: got %h expected %h", Display, Count); else passes++;
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    checks++; if (CountClr !== 1'b1) $display("FAIL rst_mid_reclear: got %b expected 1", CountClr); else passes++;
    @(negedge Clock);
    checks++; if (Count !== 16'h0000) $display("FAIL rst_mid_count: got %h expected 0000", Count); else passes++;
  endtask

  task automatic test_random();
    int busy [3];
    int r;
    int b;
    int h;
    busy = '{0, 0, 0};
    for (int c = 0; c < 500; c++) begin
      @(negedge Clock);
      checks++; if (CountEn  !== exp_en())          $display("FAIL rnd_en c%0d: got %b expected %b", c, CountEn, exp_en()); else passes++;
      checks++; if (CountClr !== m_clr)             $display("FAIL rnd_clr c%0d: got %b expected %b", c, CountClr, m_clr); else passes++;
      checks++; if (Running  !== (m_mode == M_RUN)) $display("FAIL rnd_running c%0d: got %b expected %b", c, Running, (m_mode == M_RUN)); else passes++;
      checks++; if (LapHeld  !== m_held)            $display("FAIL rnd_lap c%0d: got %b expected %b", c, LapHeld, m_held); else passes++;
      checks++; if (Overflow !== m_ovf)             $display("FAIL rnd_ovf c%0d: got %b expected %b", c, Overflow, m_ovf); else passes++;
      checks++; if (Display  !== exp_disp())        $display("FAIL rnd_disp c%0d: got %h expected %h", c, Display, exp_disp()); else passes++;
      if ($urandom_range(0, 5) == 0) begin
        r = $urandom_range(0, 9);
        b = (r < 5) ? 0 : ((r < 8) ? 1 : 2);
        if (c > busy[b]) begin
          h = $urandom_range(1, 4);
          press(b, h);
          busy[b] = c + h + 1;
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_run();
    test_pause();
    test_lap();
    test_full();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
